// File: rtl/jtpopeye_dma.sv
// Vblank DMA: grabs the Z80 bus and copies main RAM into the object buffer.
// One transfer per vblank start; a vblank lost before the grant is skipped.
module jtpopeye_dma #(
  parameter logic [10:0] SRC_BASE = 11'h400,
  parameter logic [9:0]  LEN      = 10'd512,
  parameter int          OAW      = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           LVBL,
  output logic           bus_req,
  input  logic           busak_n,
  output logic           dmcs,
  output logic [10:0]    dma_addr,
  input  logic [7:0]     ram_dout,
  output logic [OAW-1:0] obj_addr,
  output logic [7:0]     obj_data,
  output logic           obj_we,
  output logic           busy,
  output logic           done,
  output logic           skip
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    XFER,
    DRAIN,
    REL
  } state_t;

  state_t     state, state_nx;
  logic [9:0] cnt, cnt_nx;
  logic       lvbl_l;
  logic       done_r, done_nx;
  logic       skip_r, skip_nx;
  logic       in_bus;
  logic       wr_en;
  logic [9:0] wr_idx;

  // state, byte counter, vblank history and pulse flags advance on cen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      lvbl_l <= 1'b0;
      done_r <= 1'b0;
      skip_r <= 1'b0;
    end else if (cen) begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      lvbl_l <= LVBL;
      done_r <= done_nx;
      skip_r <= skip_nx;
    end
  end

  // next-state: request, sweep, drain the last read, hand the bus back
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    skip_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (lvbl_l && !LVBL) begin
          state_nx = REQ;
          cnt_nx   = '0;
        end
      end
      REQ: begin
        if (!busak_n) begin
          state_nx = XFER;
        end else if (LVBL) begin
          skip_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      XFER: begin
        cnt_nx = cnt + 10'd1;
        if (cnt == LEN - 10'd1) state_nx = DRAIN;
      end
      DRAIN: state_nx = REL;
      REL: begin
        if (busak_n) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // read data lags the address by one tick, so writes trail by one byte
  always_comb begin
    in_bus   = (state == XFER) || (state == DRAIN);
    wr_en    = ((state == XFER) && (cnt != 10'd0))
             || (state == DRAIN);
    wr_idx   = cnt - 10'd1;
    bus_req  = (state == REQ) || in_bus;
    dmcs     = in_bus;
    dma_addr = in_bus ? SRC_BASE + {1'b0, cnt} : 11'd0;
    obj_addr = wr_en ? wr_idx[OAW-1:0] : '0;
    obj_data = wr_en ? ram_dout : 8'd0;
    obj_we   = wr_en & cen;
    busy     = (state != IDLE);
    done     = done_r & cen;
    skip     = skip_r & cen;
  end

endmodule

// File: tb/tb_jtpopeye_dma.sv
// Directed bench for jtpopeye_dma: full sweeps, skip, wrap,
// re-trigger immunity, async reset and slow cen with late release.
module tb_jtpopeye_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic        lvbl = 1'b1;
  logic        busak_n = 1'b1;
  logic        bus_req, dmcs, obj_we, busy, done, skip;
  logic [10:0] dma_addr;
  logic [7:0]  ram_dout = 8'd0;
  logic [9:0]  obj_addr;
  logic [7:0]  obj_data;

  logic        lvbl2 = 1'b1;
  logic        busak2 = 1'b1;
  logic        bus_req2, dmcs2, obj_we2, busy2, done2, skip2;
  logic [10:0] dma_addr2;
  logic [7:0]  ram_dout2 = 8'd0;
  logic [9:0]  obj_addr2;
  logic [7:0]  obj_data2;

  int cen_div = 1;
  int dc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] obj_mem [1024];
  int wr_cnt = 0;
  int misal = 0;
  int done_cnt = 0;
  int skip_cnt = 0;
  int dmcs_ticks = 0;
  int dmcs_nogrant = 0;

  jtpopeye_dma dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(lvbl),
    .bus_req(bus_req), .busak_n(busak_n), .dmcs(dmcs),
    .dma_addr(dma_addr), .ram_dout(ram_dout),
    .obj_addr(obj_addr), .obj_data(obj_data), .obj_we(obj_we),
    .busy(busy), .done(done), .skip(skip)
  );

  jtpopeye_dma #(.SRC_BASE(11'h7F0), .LEN(10'd32), .OAW(10)) dut2 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .LVBL(lvbl2),
    .bus_req(bus_req2), .busak_n(busak2), .dmcs(dmcs2),
    .dma_addr(dma_addr2), .ram_dout(ram_dout2),
    .obj_addr(obj_addr2), .obj_data(obj_data2), .obj_we(obj_we2),
    .busy(busy2), .done(done2), .skip(skip2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dc >= cen_div - 1) dc <= 0;
    else dc <= dc + 1;
    cen <= (dc >= cen_div - 1);
  end

  always @(posedge clk) begin
    if (cen) begin
      ram_dout  <= dma_addr[7:0] ^ 8'h5A;
      ram_dout2 <= dma_addr2[7:0] ^ 8'h5A;
    end
    if (dmcs && busak_n) dmcs_nogrant++;
  end

  always @(negedge clk) begin
    if (obj_we) begin
      obj_mem[obj_addr] = obj_data;
      wr_cnt++;
      if (!cen) misal++;
    end
    if (done) done_cnt++;
    if (skip) skip_cnt++;
    if (dmcs) dmcs_ticks++;
  end

  task automatic cen_tick();
    do @(negedge clk); while (!cen);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cen_tick();
  endtask

  task automatic clear_obj();
    #1;
    for (int i = 0; i < 1024; i++) obj_mem[i] = 8'hxx;
  endtask

  task automatic start_xfer(input int gdly);
    lvbl = 1'b1;
    ticks(2);
    lvbl = 1'b0;
    cen_tick();
    ticks(gdly);
    busak_n = 1'b0;
  endtask

  task automatic run_to_done(input int rel_dly, output int rel_wait,
                             output bit early, output bit ok);
    int rc;
    rc = 0;
    rel_wait = 0;
    early = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      cen_tick();
      if (done) begin
        if (!busak_n) early = 1'b1;
        ok = 1'b1;
        break;
      end
      if (!bus_req && !busak_n) begin
        rel_wait++;
        if (rc >= rel_dly) busak_n = 1'b1;
        else rc++;
      end
    end
  endtask

  task automatic test_reset();
    logic [39:0] outs;
    rst_n = 1'b0;
    ticks(3);
    outs = {bus_req, dmcs, dma_addr, obj_addr, obj_data,
            obj_we, busy, done, skip};
    n_cmp++;
    if (outs !== 40'd0) begin
      n_bad++;
      $display("FAIL reset_outs got %h want 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);
  endtask

  task automatic test_basic();
    int w0, d0, rw, bad;
    bit early, ok;
    clear_obj();
    w0 = wr_cnt;
    d0 = done_cnt;
    start_xfer(3);
    cen_tick();
    n_cmp++;
    if ({dmcs, obj_we, dma_addr} !== {1'b1, 1'b0, 11'h400}) begin
      n_bad++;
      $display("FAIL first_addr got %b %b %h want 1 0 400",
               dmcs, obj_we, dma_addr);
    end
    cen_tick();
    n_cmp++;
    if ({obj_we, obj_addr, obj_data} !== {1'b1, 10'd0, 8'h5A}) begin
      n_bad++;
      $display("FAIL first_write got %b %h %h want 1 000 5a",
               obj_we, obj_addr, obj_data);
    end
    run_to_done(0, rw, early, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL basic_done got timeout want done");
    end
    #1;
    n_cmp++;
    if (wr_cnt - w0 !== 512) begin
      n_bad++;
      $display("FAIL basic_writes got %0d want 512", wr_cnt - w0);
    end
    bad = 0;
    for (int i = 0; i < 512; i++) begin
      logic [7:0] e;
      e = 8'(i) ^ 8'h5A;
      if (obj_mem[i] !== e) begin
        if (bad == 0)
          $display("FAIL basic_data[%0d] got %h want %h",
                   i, obj_mem[i], e);
        bad++;
      end
    end
    n_cmp++;
    if (bad != 0) n_bad++;
    cen_tick();
    n_cmp++;
    if ({busy, done_cnt - d0} !== {1'b0, 32'd1}) begin
      n_bad++;
      $display("FAIL basic_end got busy=%b dones=%0d want 0 1",
               busy, done_cnt - d0);
    end
  endtask

  task automatic test_skip();
    int w0, s0, m0;
    w0 = wr_cnt;
    s0 = skip_cnt;
    m0 = dmcs_ticks;
    lvbl = 1'b1;
    ticks(2);
    lvbl = 1'b0;
    ticks(4);
    n_cmp++;
    if (bus_req !== 1'b1) begin
      n_bad++;
      $display("FAIL skip_req got %b want 1", bus_req);
    end
    lvbl = 1'b1;
    ticks(3);
    #1;
    n_cmp++;
    if ({bus_req, busy, skip_cnt - s0} !== {2'b00, 32'd1}) begin
      n_bad++;
      $display("FAIL skip_pulse got req=%b busy=%b skips=%0d want 0 0 1",
               bus_req, busy, skip_cnt - s0);
    end
    n_cmp++;
    if ({wr_cnt - w0, dmcs_ticks - m0} !== 64'd0) begin
      n_bad++;
      $display("FAIL skip_quiet got we=%0d dmcs=%0d want 0 0",
               wr_cnt - w0, dmcs_ticks - m0);
    end
  endtask

  task automatic test_wrap();
    int k, j, bad;
    bit fin;
    k = 0;
    j = 0;
    bad = 0;
    fin = 1'b0;
    lvbl2 = 1'b1;
    ticks(2);
    lvbl2 = 1'b0;
    cen_tick();
    busak2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      logic [10:0] ea;
      logic [7:0]  ed;
      cen_tick();
      if (dmcs2) begin
        ea = 11'h7F0 + 11'(k);
        if (dma_addr2 !== ea) begin
          if (bad == 0)
            $display("FAIL wrap_addr[%0d] got %h want %h", k, dma_addr2, ea);
          bad++;
        end
        k++;
      end
      if (obj_we2) begin
        ea = 11'h7F0 + 11'(j);
        ed = ea[7:0] ^ 8'h5A;
        if ({obj_addr2, obj_data2} !== {10'(j), ed}) begin
          if (bad == 0)
            $display("FAIL wrap_obj[%0d] got %h %h want %h %h",
                     j, obj_addr2, obj_data2, j, ed);
          bad++;
        end
        j++;
      end
      if (!bus_req2) busak2 = 1'b1;
      if (done2) begin
        fin = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (bad != 0) n_bad++;
    n_cmp++;
    if ({fin, 32'(k), 32'(j)} !== {1'b1, 32'd33, 32'd32}) begin
      n_bad++;
      $display("FAIL wrap_count got done=%b addrs=%0d writes=%0d want 1 33 32",
               fin, k, j);
    end
  endtask

  task automatic test_retrigger();
    int w0, d0, s0, rw;
    bit early, ok;
    w0 = wr_cnt;
    d0 = done_cnt;
    s0 = skip_cnt;
    start_xfer(1);
    ticks(50);
    lvbl = 1'b1;
    ticks(3);
    lvbl = 1'b0;
    ticks(3);
    run_to_done(1, rw, early, ok);
    ticks(20);
    #1;
    n_cmp++;
    if ({ok, busy, wr_cnt - w0} !== {2'b10, 32'd512}) begin
      n_bad++;
      $display("FAIL retrig_xfer got ok=%b busy=%b writes=%0d want 1 0 512",
               ok, busy, wr_cnt - w0);
    end
    n_cmp++;
    if ({done_cnt - d0, skip_cnt - s0} !== {32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL retrig_pulses got dones=%0d skips=%0d want 1 0",
               done_cnt - d0, skip_cnt - s0);
    end
  endtask

  task automatic test_async_reset();
    int w0, rw, bad;
    bit early, ok;
    w0 = wr_cnt;
    start_xfer(2);
    for (int i = 0; i < 2000; i++) begin
      cen_tick();
      #1;
      if (wr_cnt - w0 >= 100) break;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_req, dmcs, obj_we, busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_drop got req=%b cs=%b we=%b busy=%b want 0 0 0 0",
               bus_req, dmcs, obj_we, busy);
    end
    busak_n = 1'b1;
    ticks(3);
    rst_n = 1'b1;
    ticks(2);
    clear_obj();
    w0 = wr_cnt;
    start_xfer(2);
    run_to_done(0, rw, early, ok);
    #1;
    n_cmp++;
    if ({ok, wr_cnt - w0} !== {1'b1, 32'd512}) begin
      n_bad++;
      $display("FAIL rst_rerun got ok=%b writes=%0d want 1 512",
               ok, wr_cnt - w0);
    end
    bad = 0;
    for (int i = 0; i < 512; i++)
      if (obj_mem[i] !== (8'(i) ^ 8'h5A)) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL rst_rerun_data got %0d bad bytes want 0", bad);
    end
  endtask

  task automatic test_slow_cen();
    int w0, d0, m0, rw;
    bit early, ok;
    @(negedge clk);
    cen_div = 4;
    ticks(2);
    #1;
    w0 = wr_cnt;
    d0 = done_cnt;
    m0 = misal;
    start_xfer(2);
    run_to_done(5, rw, early, ok);
    ticks(3);
    #1;
    n_cmp++;
    if ({ok, early, wr_cnt - w0} !== {2'b10, 32'd512}) begin
      n_bad++;
      $display("FAIL slow_xfer got ok=%b early=%b writes=%0d want 1 0 512",
               ok, early, wr_cnt - w0);
    end
    n_cmp++;
    if (rw < 6) begin
      n_bad++;
      $display("FAIL slow_release got rel_ticks=%0d want >=6", rw);
    end
    n_cmp++;
    if ({done_cnt - d0, misal - m0} !== {32'd1, 32'd0}) begin
      n_bad++;
      $display("FAIL slow_align got dones=%0d misaligned=%0d want 1 0",
               done_cnt - d0, misal - m0);
    end
    n_cmp++;
    if (dmcs_nogrant !== 0) begin
      n_bad++;
      $display("FAIL dmcs_grant got %0d ungranted cs want 0", dmcs_nogrant);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skip();
    test_wrap();
    test_retrigger();
    test_async_reset();
    test_slow_cen();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
